// File: rtl/qspi_xip_line_reader.sv
// Line-fill engine for the XIP cache: one Fast Read Quad I/O (0xEB) transaction
// per request, returning an aligned LINE_SIZE-byte line.
module qspi_xip_line_reader #(
    parameter int          LINE_SIZE = 16,
    parameter int          DUMMY     = 4,
    parameter logic [7:0]  MODE_BYTE = 8'h00
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     rd,
    input  logic [23:0]              addr,
    output logic                     busy,
    output logic                     done,
    output logic [8*LINE_SIZE-1:0]   line_data,
    output logic                     sck,
    output logic                     ce_n,
    output logic [3:0]               dout,
    output logic                     douten,
    input  logic [3:0]               din
);
    localparam int OFS = $clog2(LINE_SIZE);
    localparam int NIB = 2 * LINE_SIZE;
    localparam int NW  = $clog2(NIB);
    localparam logic [7:0] CMD_QIOR = 8'hEB;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [5:0]             cnt;
    logic                   ph;
    logic [5:0]             len;
    logic                   last;
    logic [23:0]            a_q;
    logic [NIB-1:0][3:0]    fill_q, fill_nxt;
    logic                   unused_lsb;

    assign unused_lsb = ^addr[OFS-1:0];

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_q;
        len       = 6'd0;
        busy      = 1'b1;
        done      = 1'b0;
        ce_n      = 1'b0;
        sck       = ph;
        dout      = 4'h0;
        douten    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                ce_n = 1'b1;
                sck  = 1'b0;
                if (rd) state_nxt = S_CMD;
            end
            S_CMD: begin
                // SIO2/3 double as WP#/HOLD# during single-bit command phase
                len    = 6'd8;
                douten = 1'b1;
                dout   = {3'b111, CMD_QIOR[3'd7 - cnt[2:0]]};
            end
            S_ADDR: begin
                len    = 6'd6;
                douten = 1'b1;
                dout   = a_q[23:20];
            end
            S_MODE: begin
                len    = 6'd2;
                douten = 1'b1;
                dout   = cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            end
            S_DUMMY: len = 6'(DUMMY);
            S_DATA: begin
                len = 6'(NIB);
                // high nibble arrives first, so even counts land in the upper nibble
                if (ph) fill_nxt[cnt[NW-1:0] ^ NW'(1)] = din;
            end
            S_DONE: begin
                ce_n      = 1'b1;
                sck       = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        last = ph && (cnt == len - 6'd1);
        if (last) begin
            case (state)
                S_CMD:   state_nxt = S_ADDR;
                S_ADDR:  state_nxt = S_MODE;
                S_MODE:  state_nxt = S_DUMMY;
                S_DUMMY: state_nxt = S_DATA;
                S_DATA:  state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ph        <= 1'b0;
            a_q       <= '0;
            fill_q    <= '0;
            line_data <= '0;
        end else begin
            state  <= state_nxt;
            fill_q <= fill_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
                ph  <= 1'b0;
            end else if (state != S_IDLE && state != S_DONE) begin
                ph <= ~ph;
                if (ph) cnt <= cnt + 6'd1;
            end
            if (state == S_IDLE && rd)
                a_q <= {addr[23:OFS], {OFS{1'b0}}};
            else if (state == S_ADDR && ph)
                a_q <= a_q << 4;
            // publish including the final nibble so line_data is valid with done
            if (state == S_DATA && last)
                line_data <= fill_nxt;
        end
    end
endmodule

// File: tb/tb_qspi_xip_line_reader.sv
// Bench for qspi_xip_line_reader: behavioural flash on the SIO pins plus a
// scoreboard of expected lines checked on each done pulse.
`timescale 1ns/1ps
module tb_qspi_xip_line_reader;
    localparam int LS = 16;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic            rd = 1'b0;
    logic [23:0]     addr = '0;
    logic            busy, done, sck, ce_n, douten;
    logic [8*LS-1:0] line_data;
    logic [3:0]      dout, din;

    qspi_xip_line_reader #(.LINE_SIZE(LS), .DUMMY(4), .MODE_BYTE(8'h00)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .rd(rd), .addr(addr), .busy(busy),
        .done(done), .line_data(line_data), .sck(sck), .ce_n(ce_n),
        .dout(dout), .douten(douten), .din(din)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { logic [23:0] a; logic [8*LS-1:0] line; } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [23:0] a);
        return {a[3:0], a[3:0]} ^ a[11:4];
    endfunction

    function automatic logic [8*LS-1:0] line_of(input logic [23:0] a);
        logic [8*LS-1:0] l;
        for (int i = 0; i < LS; i++) l[8*i +: 8] = mem(a + 24'(i));
        return l;
    endfunction

    // flash-side view of the pins
    int          rise = 0;
    int          hi_run = 0;
    int          fills_done = 0;
    int          dir_bad = 0;
    int          sio_bad = 0;
    logic        sck_d = 1'b0;
    logic        ce_d = 1'b1;
    logic [7:0]  cmd_sh = '0;
    logic [7:0]  mode_sh = '0;
    logic [23:0] fa = '0;

    always_comb begin
        logic [7:0] b;
        int j;
        din = 4'h0;
        if (rise >= 21) begin
            j   = rise - 21;
            b   = mem(fa + 24'(j / 2));
            din = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (done) begin
            fills_done++;
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("line_data", line_data, e.line);
                chk("addr_sent", fa, e.a);
                chk("cmd_sent", cmd_sh, 8'hEB);
                chk("mode_sent", mode_sh, 8'h00);
                chk("sck_rises", rise, 52);
                chk("douten_turnaround", dir_bad, 0);
                chk("cmd_sio", sio_bad, 0);
            end
        end
        if (ce_n) begin
            rise = 0; dir_bad = 0; sio_bad = 0;
            hi_run++;
        end else begin
            if (ce_d) begin
                if (fills_done > 0) chk("ce_hi_time", hi_run >= 2, 1);
                hi_run = 0;
            end
            if (sck && !sck_d) begin
                rise++;
                if (rise <= 8) begin
                    cmd_sh = {cmd_sh[6:0], dout[0]};
                    if (dout[3:1] != 3'b111 || !douten) sio_bad++;
                end else if (rise <= 14) fa = {fa[19:0], dout};
                else if (rise <= 16) mode_sh = {mode_sh[3:0], dout};
            end
            if ((rise > 16 || (rise == 16 && !sck)) && douten) dir_bad++;
        end
        sck_d = sck;
        ce_d  = ce_n;
    end

    task automatic start(input logic [23:0] a);
        exp_t e;
        @(posedge HCLK); #1;
        rd = 1'b1; addr = a;
        e.a = {a[23:4], 4'h0};
        e.line = line_of(e.a);
        sb.push_back(e);
        @(posedge HCLK); #1;
        rd = 1'b0; addr = 24'($urandom);
    endtask

    // waits for done; optional stray rd pulse at cycle pulse_at
    task automatic finish_fill(input int pulse_at);
        int n = 1;
        while (!done && n < 300) begin
            @(posedge HCLK); #1;
            n++;
            rd = (n == pulse_at);
            if (n == pulse_at) addr = 24'h000010;
        end
        rd = 1'b0;
        chk("latency", n, 105);
    endtask

    initial begin
        #1;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_douten", douten, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_line", line_data, 0);
        #20 HRESETn = 1'b1;

        // single aligned fill
        start(24'h000000);
        chk("busy_after_rd", busy, 1);
        finish_fill(0);

        // rd during DONE is ignored
        rd = 1'b1;
        @(posedge HCLK); #1;
        rd = 1'b0;
        chk("ign_done_busy", busy, 0);

        // unaligned request, line data must hold while next fill runs
        start(24'h000017);
        chk("line_hold", line_data, line_of(24'h0));
        finish_fill(30);
        repeat (3) @(posedge HCLK);
        #1 chk("no_queued_rd", busy, 0);

        // back-to-back with a stray pulse mid-transfer
        start(24'h000000);
        finish_fill(50);
        start(24'h000010);
        finish_fill(0);

        // abort mid-fill
        start(24'h000020);
        repeat (38) @(posedge HCLK);
        #1 HRESETn = 1'b0;
        #1;
        chk("abort_ce_n", ce_n, 1);
        chk("abort_douten", douten, 0);
        chk("abort_busy", busy, 0);
        chk("abort_line", line_data, 0);
        sb.delete();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // fill at top of address space after abort
        start(24'hFFFFF7);
        finish_fill(0);
        repeat (4) @(posedge HCLK);
        #1 chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
